dvi_frame_arbiter: RTL and testbench

Shares the single 24-bit DVI pixel output between up to NUM_SRC pixel sources, such as the colour pattern, the bouncing ball, line overlays and future sources. Ownership changes only on frame boundaries, so a switch never tears a visible frame. The block sits between the vga_core timing/pixel generators and the DDR SB_IO output stage.
- Applies startup blanking after reset.
- Applies a minimum-dwell policy per owner.
- Applies round-robin arbitration between requesters.

---
 rtl/dvi_pkg.sv | 18 +
 rtl/rr_pick.sv | 31 +++
 rtl/dvi_frame_arbiter.sv | 132 +++++++++++++
 tb/tb_dvi_frame_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dvi_pkg.sv
// rtl/dvi_pkg.sv - shared types and constants for the DVI frame arbiter
package dvi_pkg;

    localparam int RGB_W = 24;
    localparam logic [RGB_W-1:0] BG_BLACK = 24'h000000;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_OWN  = 2'd2
    } state_e;

    // A zero-frame dwell still needs a 1-bit counter to hold the grant marker.
    function automatic int dwell_w(input int min_dwell);
        return (min_dwell < 1) ? 1 : $clog2(min_dwell + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker with start pointer and exclude mask
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    input  logic [N-1:0]  excl_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int j;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(start_i) + k) % N;
            if (!valid_o && req_i[j] && !excl_i[j]) begin
                valid_o  = 1'b1;
                idx_o    = IW'(j);
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dvi_frame_arbiter.sv
// rtl/dvi_frame_arbiter.sv - frame-boundary arbiter sharing one DVI pixel output between sources
module dvi_frame_arbiter
    import dvi_pkg::*;
#(
    parameter int               NUM_SRC      = 4,
    parameter int               BLANK_FRAMES = 2,
    parameter int               MIN_DWELL    = 60,
    parameter logic [RGB_W-1:0] BG_RGB       = BG_BLACK,
    parameter bit               VS_ACTIVE    = 1'b1
) (
    input  logic                       clk_dot,
    input  logic                       reset_n,
    input  logic                       vga_de,
    input  logic                       vga_hs,
    input  logic                       vga_vs,
    input  logic [NUM_SRC-1:0]         src_req,
    input  logic [NUM_SRC*RGB_W-1:0]   src_rgb,
    output logic [NUM_SRC-1:0]         src_gnt,
    output logic [RGB_W-1:0]           out_rgb,
    output logic                       out_de,
    output logic                       out_hs,
    output logic                       out_vs,
    output logic                       frame_strobe,
    output logic [15:0]                frame_cnt,
    output logic                       blanking
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int DW = dwell_w(MIN_DWELL);
    localparam int BW = (BLANK_FRAMES < 1) ? 1 : $clog2(BLANK_FRAMES + 1);

    state_e             state_q;
    logic [BW-1:0]      blank_cnt_q;
    logic [DW-1:0]      dwell_cnt_q;
    logic [IW-1:0]      rr_ptr_q;
    logic [NUM_SRC-1:0] gnt_q;
    logic               vs_p1_q, strobe_q, blanking_q;
    logic               out_de_q, out_hs_q, out_vs_q;
    logic [15:0]        frame_cnt_q;
    logic [RGB_W-1:0]   out_rgb_q, mux_rgb;

    logic               boundary, owner_req, others_req, dwell_done, blank_done, do_pick;
    logic [IW-1:0]      start_ptr;
    logic [NUM_SRC-1:0] excl, pk_gnt;
    logic [IW-1:0]      pk_idx;
    logic               pk_valid;

    assign boundary   = (vga_vs == VS_ACTIVE) && (vs_p1_q != VS_ACTIVE);
    assign owner_req  = |(src_req & gnt_q);
    assign others_req = |(src_req & ~gnt_q);
    assign dwell_done = dwell_cnt_q >= DW'(MIN_DWELL);
    assign blank_done = blank_cnt_q == BW'(BLANK_FRAMES);

    // rr_ptr always equals the owner while in ST_OWN, so one search start serves every case.
    assign start_ptr = (rr_ptr_q == IW'(NUM_SRC - 1)) ? '0 : rr_ptr_q + IW'(1);
    assign excl      = (state_q == ST_OWN) ? gnt_q : '0;

    assign do_pick = boundary && (((state_q == ST_INIT) && blank_done) || (state_q == ST_IDLE) ||
                     ((state_q == ST_OWN) && (!owner_req || (others_req && dwell_done))));

    rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick (
        .req_i   (src_req),
        .start_i (start_ptr),
        .excl_i  (excl),
        .gnt_o   (pk_gnt),
        .idx_o   (pk_idx),
        .valid_o (pk_valid)
    );

    always_comb begin
        mux_rgb = BG_RGB;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_q[i]) mux_rgb = src_rgb[RGB_W*i +: RGB_W];
        end
    end

    always_ff @(posedge clk_dot or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            blank_cnt_q <= '0;
            dwell_cnt_q <= '0;
            rr_ptr_q    <= IW'(NUM_SRC - 1);
            gnt_q       <= '0;
            vs_p1_q     <= 1'b0;
            strobe_q    <= 1'b0;
            blanking_q  <= 1'b0;
            out_de_q    <= 1'b0;
            out_hs_q    <= 1'b0;
            out_vs_q    <= 1'b0;
            frame_cnt_q <= '0;
            out_rgb_q   <= '0;
        end else begin
            vs_p1_q    <= vga_vs;
            strobe_q   <= boundary;
            out_de_q   <= vga_de;
            out_hs_q   <= vga_hs;
            out_vs_q   <= vga_vs;
            out_rgb_q  <= mux_rgb;
            blanking_q <= (state_q == ST_INIT);
            if (boundary) frame_cnt_q <= frame_cnt_q + 16'd1;

            if (do_pick) begin
                blanking_q <= 1'b0;
                if (pk_valid) begin
                    gnt_q       <= pk_gnt;
                    rr_ptr_q    <= pk_idx;
                    dwell_cnt_q <= DW'(1);
                    state_q     <= ST_OWN;
                end else begin
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            end else if (boundary) begin
                if (state_q == ST_INIT) begin
                    blank_cnt_q <= blank_cnt_q + BW'(1);
                end else if ((state_q == ST_OWN) && !dwell_done) begin
                    dwell_cnt_q <= dwell_cnt_q + DW'(1);
                end
            end
        end
    end

    assign src_gnt      = gnt_q;
    assign out_rgb      = out_rgb_q;
    assign out_de       = out_de_q;
    assign out_hs       = out_hs_q;
    assign out_vs       = out_vs_q;
    assign frame_strobe = strobe_q;
    assign frame_cnt    = frame_cnt_q;
    assign blanking     = blanking_q;

endmodule

// File: tb/tb_dvi_frame_arbiter.sv
// tb/tb_dvi_frame_arbiter.sv - scoreboard bench for dvi_frame_arbiter (dwell instance and rotate instance)
module tb_dvi_frame_arbiter;

    localparam int FRAME_LEN = 40;

    typedef struct packed {
        logic [3:0]  gnt;
        logic        bl;
        logic [15:0] cnt;
    } exp_t;

    logic        clk_dot = 1'b0;
    logic        reset_n = 1'b0;
    logic        vga_de = 1'b0, vga_hs = 1'b0, vga_vs = 1'b0;
    logic [3:0]  src_req = 4'b0001;
    logic [3:0]  rr_req  = 4'b1111;
    logic [95:0] src_rgb = '0;
    logic [15:0] pix = '0;

    logic [3:0]  src_gnt, rr_gnt;
    logic [23:0] out_rgb, rr_rgb;
    logic        out_de, out_hs, out_vs, frame_strobe, blanking;
    logic        rr_de, rr_hs, rr_vs, rr_strobe, rr_blanking;
    logic [15:0] frame_cnt, rr_cnt;

    int passed = 0;
    int total  = 0;

    exp_t       exp_q[$];
    logic [3:0] rr_q[$];

    always #5 clk_dot = ~clk_dot;

    dvi_frame_arbiter #(.NUM_SRC(4), .BLANK_FRAMES(2), .MIN_DWELL(3), .BG_RGB(24'h000000), .VS_ACTIVE(1'b1)) dut (
        .clk_dot(clk_dot), .reset_n(reset_n), .vga_de(vga_de), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .src_req(src_req), .src_rgb(src_rgb), .src_gnt(src_gnt), .out_rgb(out_rgb),
        .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs), .frame_strobe(frame_strobe),
        .frame_cnt(frame_cnt), .blanking(blanking)
    );

    dvi_frame_arbiter #(.NUM_SRC(4), .BLANK_FRAMES(0), .MIN_DWELL(0), .BG_RGB(24'h000000), .VS_ACTIVE(1'b1)) dut_rr (
        .clk_dot(clk_dot), .reset_n(reset_n), .vga_de(vga_de), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .src_req(rr_req), .src_rgb(src_rgb), .src_gnt(rr_gnt), .out_rgb(rr_rgb),
        .out_de(rr_de), .out_hs(rr_hs), .out_vs(rr_vs), .frame_strobe(rr_strobe),
        .frame_cnt(rr_cnt), .blanking(rr_blanking)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [23:0] exp_pix(input logic [3:0] g, input logic [95:0] rgb);
        logic [23:0] r;
        r = 24'h000000;
        for (int i = 0; i < 4; i++) if (g[i]) r = rgb[24*i +: 24];
        return r;
    endfunction

    // Monitor for the dwell instance: frame decisions from the queue, pixel path against last cycle's inputs.
    logic [3:0]  cur_gnt = '0, sv_gnt = '0;
    logic [95:0] sv_rgb = '0;
    logic        sv_de = 1'b0, sv_hs = 1'b0, sv_vs = 1'b0, hold = 1'b1;
    always @(negedge clk_dot) begin
        exp_t e;
        if (!reset_n) begin
            cur_gnt = '0;
            hold    = 1'b1;
        end else begin
            if (frame_strobe) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL frame_state: unexpected strobe, frame_cnt %h at %0t", frame_cnt, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_state", {11'd0, src_gnt, blanking, frame_cnt}, {11'd0, e});
                    cur_gnt = e.gnt;
                end
            end
            if (hold) hold = 1'b0;
            else check("pixel_path", {5'd0, out_rgb, out_de, out_hs, out_vs},
                       {5'd0, exp_pix(sv_gnt, sv_rgb), sv_de, sv_hs, sv_vs});
        end
        sv_gnt = cur_gnt; sv_rgb = src_rgb; sv_de = vga_de; sv_hs = vga_hs; sv_vs = vga_vs;
    end

    logic [3:0]  rr_cur = '0, rr_sv_gnt = '0;
    logic [95:0] rr_sv_rgb = '0;
    logic        rr_hold = 1'b1;
    always @(negedge clk_dot) begin
        logic [3:0] g;
        if (!reset_n) begin
            rr_cur  = '0;
            rr_hold = 1'b1;
        end else begin
            if (rr_strobe) begin
                if (rr_q.size() == 0) begin
                    total++;
                    $display("FAIL rr_grant: unexpected strobe at %0t", $time);
                end else begin
                    g = rr_q.pop_front();
                    check("rr_grant", {27'd0, rr_gnt, rr_blanking}, {27'd0, g, 1'b0});
                    rr_cur = g;
                end
            end
            if (rr_hold) rr_hold = 1'b0;
            else check("rr_pixel", {8'd0, rr_rgb}, {8'd0, exp_pix(rr_sv_gnt, rr_sv_rgb)});
        end
        rr_sv_gnt = rr_cur; rr_sv_rgb = src_rgb;
    end

    task automatic drive_pix();
        pix = pix + 16'd1;
        for (int i = 0; i < 4; i++) src_rgb[24*i +: 24] = {4'(i + 1), 4'hA, pix};
    endtask

    task automatic frame(input logic [3:0] eg, input logic eb, input logic [15:0] ec,
                         input logic [3:0] erg, input logic [3:0] req_mid, input bit do_reset);
        exp_q.push_back('{gnt: eg, bl: eb, cnt: ec});
        rr_q.push_back(erg);
        for (int c = 0; c < FRAME_LEN; c++) begin
            @(posedge clk_dot); #1;
            vga_vs = (c < 3);
            vga_hs = ((c % 10) < 2);
            vga_de = (c >= 10) && ((c % 10) >= 3);
            drive_pix();
            if (c == 20) src_req = req_mid;
            if (do_reset && c == 25) begin
                #2 reset_n = 1'b0;
                #1;
                check("reset_zero", {src_gnt, out_rgb, out_de, out_hs, out_vs},  32'd0);
                check("reset_zero2", {13'd0, frame_strobe, frame_cnt, blanking, rr_gnt[0], rr_strobe}, 32'd0);
                check("reset_zero_rr", {rr_gnt, rr_rgb, rr_de, rr_hs, rr_vs}, 32'd0);
                repeat (4) @(posedge clk_dot);
                #1 reset_n = 1'b1;
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_dot);
        #1 reset_n = 1'b1;
        repeat (7) begin
            @(posedge clk_dot); #1;
            drive_pix();
        end
        //     gnt      bl  cnt    rr       req_mid  rst
        frame(4'b0000, 1, 16'd1, 4'b0001, 4'b0001, 0);
        frame(4'b0000, 1, 16'd2, 4'b0010, 4'b0001, 0);
        frame(4'b0001, 0, 16'd3, 4'b0100, 4'b0101, 0);
        frame(4'b0001, 0, 16'd4, 4'b1000, 4'b0101, 0);
        frame(4'b0001, 0, 16'd5, 4'b0001, 4'b0101, 0);
        frame(4'b0100, 0, 16'd6, 4'b0010, 4'b0000, 0);
        frame(4'b0000, 0, 16'd7, 4'b0100, 4'b0100, 0);
        frame(4'b0100, 0, 16'd8, 4'b1000, 4'b0100, 0);
        frame(4'b0100, 0, 16'd9, 4'b0001, 4'b0100, 0);
        frame(4'b0100, 0, 16'd10, 4'b0010, 4'b0100, 1);
        frame(4'b0000, 1, 16'd1, 4'b0001, 4'b0100, 0);
        frame(4'b0000, 1, 16'd2, 4'b0010, 4'b0100, 0);
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk_dot); #1;
        release dut.frame_cnt_q;
        frame(4'b0100, 0, 16'd0, 4'b0100, 4'b0100, 0);
        frame(4'b0100, 0, 16'd1, 4'b1000, 4'b0100, 0);
        repeat (4) @(posedge clk_dot);
        #1;
        check("exp_queue_drained", exp_q.size(), 32'd0);
        check("rr_queue_drained", rr_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
